// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants and types for the ID-stage hazard/control unit.
// Holds the opcode/func encodings, aluc codes, forwarding and pcsource select
// codes, the EX/MEM stage record and the forwarding-select helper.
package pipe_pkg;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned OP_W   = 6;
  localparam int unsigned ALUC_W = 4;
  localparam int unsigned SEL_W  = 2;

  // Primary opcodes
  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_XORI  = 6'b001110;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;

  // R-type func codes
  localparam logic [OP_W-1:0] FN_ADD  = 6'b100000;
  localparam logic [OP_W-1:0] FN_SUB  = 6'b100010;
  localparam logic [OP_W-1:0] FN_AND  = 6'b100100;
  localparam logic [OP_W-1:0] FN_OR   = 6'b100101;
  localparam logic [OP_W-1:0] FN_XOR  = 6'b100110;
  localparam logic [OP_W-1:0] FN_SLL  = 6'b000000;
  localparam logic [OP_W-1:0] FN_SRL  = 6'b000010;
  localparam logic [OP_W-1:0] FN_SRA  = 6'b000011;
  localparam logic [OP_W-1:0] FN_SLLV = 6'b000100;
  localparam logic [OP_W-1:0] FN_SRLV = 6'b000110;
  localparam logic [OP_W-1:0] FN_SRAV = 6'b000111;
  localparam logic [OP_W-1:0] FN_JR   = 6'b001000;
  localparam logic [OP_W-1:0] FN_MULT = 6'b011000;
  localparam logic [OP_W-1:0] FN_MFLO = 6'b010010;

  // ALU operation codes (don't-care bits driven as 0)
  localparam logic [ALUC_W-1:0] ALUC_ADD = 4'b0000;
  localparam logic [ALUC_W-1:0] ALUC_SUB = 4'b0100;
  localparam logic [ALUC_W-1:0] ALUC_AND = 4'b0001;
  localparam logic [ALUC_W-1:0] ALUC_OR  = 4'b0101;
  localparam logic [ALUC_W-1:0] ALUC_XOR = 4'b0010;
  localparam logic [ALUC_W-1:0] ALUC_LUI = 4'b0110;
  localparam logic [ALUC_W-1:0] ALUC_SLL = 4'b0011;
  localparam logic [ALUC_W-1:0] ALUC_SRL = 4'b0111;
  localparam logic [ALUC_W-1:0] ALUC_SRA = 4'b1111;

  // Operand forwarding selects
  localparam logic [SEL_W-1:0] FWD_RF    = 2'b00;
  localparam logic [SEL_W-1:0] FWD_EXE   = 2'b01;
  localparam logic [SEL_W-1:0] FWD_MEM   = 2'b10;
  localparam logic [SEL_W-1:0] FWD_MEMLD = 2'b11;

  // Next-PC selects
  localparam logic [SEL_W-1:0] PC_SEQ    = 2'b00;
  localparam logic [SEL_W-1:0] PC_BRANCH = 2'b01;
  localparam logic [SEL_W-1:0] PC_JR     = 2'b10;
  localparam logic [SEL_W-1:0] PC_JUMP   = 2'b11;

  localparam logic [REG_W-1:0] REG_RA = 5'd31;

  // Destination record carried through EX and MEM
  typedef struct packed {
    logic             wreg;
    logic             m2reg;
    logic [REG_W-1:0] rn;
  } stage_t;

  // EX result has priority; a load still in EX cannot forward (its data is not ready)
  function automatic logic [SEL_W-1:0] fwd_sel(input logic [REG_W-1:0] src,
                                               input stage_t e, input stage_t m);
    logic [SEL_W-1:0] sel;
    sel = FWD_RF;
    if (e.wreg && (e.rn == src) && !e.m2reg) begin
      sel = FWD_EXE;
    end else if (m.wreg && (m.rn == src)) begin
      sel = m.m2reg ? FWD_MEMLD : FWD_MEM;
    end
    return sel;
  endfunction

endpackage

// File: rtl/pipe_decode.sv
// pipe_decode: combinational op/func decoder.
// Ports: valid_i (ID holds a real instruction), op_i/func_i, rt_i/rd_i,
//        rsrtequ_i -> raw controls (wreg_o already masked for $0), rn_o,
//        pcsource_o, is_mult_o/is_mflo_o, uses_rs_o/uses_rt_o.
module pipe_decode
  import pipe_pkg::*;
(
  input  logic              valid_i,
  input  logic [OP_W-1:0]   op_i,
  input  logic [OP_W-1:0]   func_i,
  input  logic [REG_W-1:0]  rt_i,
  input  logic [REG_W-1:0]  rd_i,
  input  logic              rsrtequ_i,
  output logic              wreg_o,
  output logic              m2reg_o,
  output logic              wmem_o,
  output logic [ALUC_W-1:0] aluc_o,
  output logic              aluimm_o,
  output logic              shift_o,
  output logic              sext_o,
  output logic              jal_o,
  output logic [REG_W-1:0]  rn_o,
  output logic [SEL_W-1:0]  pcsource_o,
  output logic              is_mult_o,
  output logic              is_mflo_o,
  output logic              uses_rs_o,
  output logic              uses_rt_o
);

  logic wreg_raw;
  logic dst_rt;

  // Instruction decode; nothing is decoded while ID is invalid (reset)
  always_comb begin
    wreg_raw   = 1'b0;
    dst_rt     = 1'b0;
    m2reg_o    = 1'b0;
    wmem_o     = 1'b0;
    aluc_o     = ALUC_ADD;
    aluimm_o   = 1'b0;
    shift_o    = 1'b0;
    sext_o     = 1'b0;
    jal_o      = 1'b0;
    pcsource_o = PC_SEQ;
    is_mult_o  = 1'b0;
    is_mflo_o  = 1'b0;
    uses_rs_o  = 1'b0;
    uses_rt_o  = 1'b0;
    rn_o       = '0;
    wreg_o     = 1'b0;

    if (valid_i) begin
      case (op_i)
        OP_RTYPE: begin
          case (func_i)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_SLLV, FN_SRLV, FN_SRAV: begin
              wreg_raw  = 1'b1;
              uses_rs_o = 1'b1;
              uses_rt_o = 1'b1;
            end
            FN_SLL, FN_SRL, FN_SRA: begin
              wreg_raw  = 1'b1;
              uses_rt_o = 1'b1;
              shift_o   = 1'b1;
            end
            FN_JR: begin
              uses_rs_o  = 1'b1;
              pcsource_o = PC_JR;
            end
            FN_MULT: begin
              uses_rs_o = 1'b1;
              uses_rt_o = 1'b1;
              is_mult_o = 1'b1;
            end
            FN_MFLO: begin
              wreg_raw  = 1'b1;
              is_mflo_o = 1'b1;
            end
            default: ;
          endcase
          case (func_i)
            FN_SUB:          aluc_o = ALUC_SUB;
            FN_AND:          aluc_o = ALUC_AND;
            FN_OR:           aluc_o = ALUC_OR;
            FN_XOR:          aluc_o = ALUC_XOR;
            FN_SLL, FN_SLLV: aluc_o = ALUC_SLL;
            FN_SRL, FN_SRLV: aluc_o = ALUC_SRL;
            FN_SRA, FN_SRAV: aluc_o = ALUC_SRA;
            default:         aluc_o = ALUC_ADD;
          endcase
        end
        OP_ADDI: begin
          wreg_raw = 1'b1; dst_rt = 1'b1; aluimm_o = 1'b1; sext_o = 1'b1;
          uses_rs_o = 1'b1;
        end
        OP_ANDI: begin
          wreg_raw = 1'b1; dst_rt = 1'b1; aluimm_o = 1'b1; aluc_o = ALUC_AND;
          uses_rs_o = 1'b1;
        end
        OP_ORI: begin
          wreg_raw = 1'b1; dst_rt = 1'b1; aluimm_o = 1'b1; aluc_o = ALUC_OR;
          uses_rs_o = 1'b1;
        end
        OP_XORI: begin
          wreg_raw = 1'b1; dst_rt = 1'b1; aluimm_o = 1'b1; aluc_o = ALUC_XOR;
          uses_rs_o = 1'b1;
        end
        OP_LW: begin
          wreg_raw = 1'b1; dst_rt = 1'b1; aluimm_o = 1'b1; sext_o = 1'b1;
          m2reg_o = 1'b1; uses_rs_o = 1'b1;
        end
        OP_SW: begin
          wmem_o = 1'b1; aluimm_o = 1'b1; sext_o = 1'b1;
          uses_rs_o = 1'b1; uses_rt_o = 1'b1;
        end
        OP_BEQ: begin
          aluc_o = ALUC_XOR; sext_o = 1'b1; uses_rs_o = 1'b1; uses_rt_o = 1'b1;
          pcsource_o = rsrtequ_i ? PC_BRANCH : PC_SEQ;
        end
        OP_BNE: begin
          aluc_o = ALUC_XOR; sext_o = 1'b1; uses_rs_o = 1'b1; uses_rt_o = 1'b1;
          pcsource_o = rsrtequ_i ? PC_SEQ : PC_BRANCH;
        end
        OP_LUI: begin
          wreg_raw = 1'b1; dst_rt = 1'b1; aluimm_o = 1'b1; aluc_o = ALUC_LUI;
        end
        OP_J: begin
          pcsource_o = PC_JUMP;
        end
        OP_JAL: begin
          wreg_raw = 1'b1; jal_o = 1'b1; pcsource_o = PC_JUMP;
        end
        default: ;
      endcase

      rn_o   = jal_o ? REG_RA : (dst_rt ? rt_i : rd_i);
      // $0 is hardwired; never report a write to it
      wreg_o = wreg_raw && (rn_o != '0);
    end
  end

endmodule

// File: rtl/pipe_hazard_cu.sv
// pipe_hazard_cu: ID-stage control unit with hazard detection, forwarding
// selects and a multiply-busy interlock.
// Ports: clock/reset (async, active-high); op/func/rs/rt/rd/rsrtequ from ID;
//        decoded controls wreg/m2reg/wmem/aluc/aluimm/shift/sext/jal/rn/
//        pcsource; fwda/fwdb operand selects; wpcir (0 = stall);
//        mdu_start (launch multiply); mflo (EX multiply-result select).
module pipe_hazard_cu
  import pipe_pkg::*;
#(
  parameter int unsigned MDU_LAT = 4,
  parameter int unsigned CNT_W   = $clog2(MDU_LAT + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [OP_W-1:0]   op,
  input  logic [OP_W-1:0]   func,
  input  logic [REG_W-1:0]  rs,
  input  logic [REG_W-1:0]  rt,
  input  logic [REG_W-1:0]  rd,
  input  logic              rsrtequ,
  output logic              wreg,
  output logic              m2reg,
  output logic              wmem,
  output logic [ALUC_W-1:0] aluc,
  output logic              aluimm,
  output logic              shift,
  output logic              sext,
  output logic              jal,
  output logic [REG_W-1:0]  rn,
  output logic [SEL_W-1:0]  pcsource,
  output logic [SEL_W-1:0]  fwda,
  output logic [SEL_W-1:0]  fwdb,
  output logic              wpcir,
  output logic              mdu_start,
  output logic              mflo
);

  stage_t           e_q, e_d, m_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic              d_wreg, d_wmem, d_mult, d_mflo, d_uses_rs, d_uses_rt;
  logic [SEL_W-1:0]  d_pcsource;
  logic              ld_stall, mdu_stall, stall;

  pipe_decode u_decode (
    .valid_i    (~reset),
    .op_i       (op),
    .func_i     (func),
    .rt_i       (rt),
    .rd_i       (rd),
    .rsrtequ_i  (rsrtequ),
    .wreg_o     (d_wreg),
    .m2reg_o    (m2reg),
    .wmem_o     (d_wmem),
    .aluc_o     (aluc),
    .aluimm_o   (aluimm),
    .shift_o    (shift),
    .sext_o     (sext),
    .jal_o      (jal),
    .rn_o       (rn),
    .pcsource_o (d_pcsource),
    .is_mult_o  (d_mult),
    .is_mflo_o  (d_mflo),
    .uses_rs_o  (d_uses_rs),
    .uses_rt_o  (d_uses_rt)
  );

  // Stall detection, gated ID controls, forwarding and next stage state
  always_comb begin
    ld_stall  = e_q.wreg && e_q.m2reg &&
                ((d_uses_rs && (e_q.rn == rs)) || (d_uses_rt && (e_q.rn == rt)));
    mdu_stall = (d_mult || d_mflo) && (cnt_q != '0);
    stall     = ld_stall || mdu_stall;

    wpcir     = ~stall;
    wreg      = d_wreg && !stall;
    wmem      = d_wmem && !stall;
    mdu_start = d_mult && !stall;
    pcsource  = stall ? PC_SEQ : d_pcsource;
    mflo      = d_mflo;

    fwda = fwd_sel(rs, e_q, m_q);
    fwdb = fwd_sel(rt, e_q, m_q);

    e_d = '0;
    if (!stall) begin
      e_d.wreg  = d_wreg;
      e_d.m2reg = m2reg;
      e_d.rn    = rn;
    end

    // Busy counter reloads on an accepted multiply, otherwise drains to 0
    cnt_d = cnt_q;
    if (mdu_start) begin
      cnt_d = CNT_W'(MDU_LAT);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // EX/MEM destination tracking and multiply busy counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      e_q   <= '0;
      m_q   <= '0;
      cnt_q <= '0;
    end else begin
      e_q   <= e_d;
      m_q   <= e_q;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_cu.sv
// Scoreboard bench for pipe_hazard_cu: a driver issues instructions and pushes
// the reference model's expected outputs; a monitor pops and compares.
module tb_pipe_hazard_cu;

  localparam int unsigned MDU_LAT = 4;

  localparam int K_ADD = 0,  K_SUB = 1,  K_AND = 2,  K_OR = 3,   K_XOR = 4;
  localparam int K_SLL = 5,  K_SRL = 6,  K_SRA = 7,  K_SLLV = 8, K_SRLV = 9;
  localparam int K_SRAV = 10, K_JR = 11, K_ADDI = 12, K_ANDI = 13, K_ORI = 14;
  localparam int K_XORI = 15, K_LW = 16, K_SW = 17, K_BEQ = 18, K_BNE = 19;
  localparam int K_LUI = 20, K_J = 21, K_JAL = 22, K_MULT = 23, K_MFLO = 24;
  localparam int NK = 25;

  typedef struct packed {
    logic [5:0] op;
    logic [5:0] func;
    logic [3:0] aluc;
    logic [3:0] amask;
    logic wr, ld, st, imm, sh, sx, urs, urt, drt, jl, mul, mfl, beq, bne, jr, jmp;
  } info_t;

  typedef struct packed {
    logic       wreg, m2reg, wmem;
    logic [3:0] aluc, amask;
    logic       aluimm, shift, sext, jal;
    logic [4:0] rn;
    logic [1:0] pcsource, fwda, fwdb;
    logic       wpcir, mdu_start, mflo;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = '0, func = '0;
  logic [4:0] rs = '0, rt = '0, rd = '0;
  logic       rsrtequ = 1'b0;
  logic       wreg, m2reg, wmem, aluimm, shift, sext, jal, wpcir, mdu_start, mflo;
  logic [3:0] aluc;
  logic [4:0] rn;
  logic [1:0] pcsource, fwda, fwdb;

  int n_vec = 0;
  int n_err = 0;
  exp_t sb[$];

  // Reference model state: destinations in EX and MEM, cycle of multiply completion
  bit ex_wr, ex_ld, mem_wr, mem_ld;
  int ex_dst, mem_dst;
  int cyc = 0;
  int free_at = 0;

  pipe_hazard_cu #(.MDU_LAT(MDU_LAT)) dut (
    .clock(clock), .reset(reset), .op(op), .func(func), .rs(rs), .rt(rt), .rd(rd),
    .rsrtequ(rsrtequ), .wreg(wreg), .m2reg(m2reg), .wmem(wmem), .aluc(aluc),
    .aluimm(aluimm), .shift(shift), .sext(sext), .jal(jal), .rn(rn),
    .pcsource(pcsource), .fwda(fwda), .fwdb(fwdb), .wpcir(wpcir),
    .mdu_start(mdu_start), .mflo(mflo)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  function automatic info_t info(input int k);
    info_t r;
    r = '0;
    case (k)
      K_ADD:  begin r.func = 6'h20; r.wr = 1; r.urs = 1; r.urt = 1; r.amask = 4'hF; end
      K_SUB:  begin r.func = 6'h22; r.wr = 1; r.urs = 1; r.urt = 1; r.aluc = 4'b0100; r.amask = 4'h7; end
      K_AND:  begin r.func = 6'h24; r.wr = 1; r.urs = 1; r.urt = 1; r.aluc = 4'b0001; r.amask = 4'h7; end
      K_OR:   begin r.func = 6'h25; r.wr = 1; r.urs = 1; r.urt = 1; r.aluc = 4'b0101; r.amask = 4'h7; end
      K_XOR:  begin r.func = 6'h26; r.wr = 1; r.urs = 1; r.urt = 1; r.aluc = 4'b0010; r.amask = 4'h7; end
      K_SLL:  begin r.func = 6'h00; r.wr = 1; r.urt = 1; r.sh = 1; r.aluc = 4'b0011; r.amask = 4'hF; end
      K_SRL:  begin r.func = 6'h02; r.wr = 1; r.urt = 1; r.sh = 1; r.aluc = 4'b0111; r.amask = 4'hF; end
      K_SRA:  begin r.func = 6'h03; r.wr = 1; r.urt = 1; r.sh = 1; r.aluc = 4'b1111; r.amask = 4'hF; end
      K_SLLV: begin r.func = 6'h04; r.wr = 1; r.urs = 1; r.urt = 1; r.aluc = 4'b0011; r.amask = 4'hF; end
      K_SRLV: begin r.func = 6'h06; r.wr = 1; r.urs = 1; r.urt = 1; r.aluc = 4'b0111; r.amask = 4'hF; end
      K_SRAV: begin r.func = 6'h07; r.wr = 1; r.urs = 1; r.urt = 1; r.aluc = 4'b1111; r.amask = 4'hF; end
      K_JR:   begin r.func = 6'h08; r.urs = 1; r.jr = 1; end
      K_ADDI: begin r.op = 6'h08; r.wr = 1; r.urs = 1; r.drt = 1; r.imm = 1; r.sx = 1; r.amask = 4'hF; end
      K_ANDI: begin r.op = 6'h0C; r.wr = 1; r.urs = 1; r.drt = 1; r.imm = 1; r.aluc = 4'b0001; r.amask = 4'h7; end
      K_ORI:  begin r.op = 6'h0D; r.wr = 1; r.urs = 1; r.drt = 1; r.imm = 1; r.aluc = 4'b0101; r.amask = 4'h7; end
      K_XORI: begin r.op = 6'h0E; r.wr = 1; r.urs = 1; r.drt = 1; r.imm = 1; r.aluc = 4'b0010; r.amask = 4'h7; end
      K_LW:   begin r.op = 6'h23; r.wr = 1; r.ld = 1; r.urs = 1; r.drt = 1; r.imm = 1; r.sx = 1; r.amask = 4'hF; end
      K_SW:   begin r.op = 6'h2B; r.st = 1; r.urs = 1; r.urt = 1; r.imm = 1; r.sx = 1; r.amask = 4'hF; end
      K_BEQ:  begin r.op = 6'h04; r.beq = 1; r.urs = 1; r.urt = 1; r.sx = 1; r.aluc = 4'b0010; r.amask = 4'h7; end
      K_BNE:  begin r.op = 6'h05; r.bne = 1; r.urs = 1; r.urt = 1; r.sx = 1; r.aluc = 4'b0010; r.amask = 4'h7; end
      K_LUI:  begin r.op = 6'h0F; r.wr = 1; r.drt = 1; r.imm = 1; r.aluc = 4'b0110; r.amask = 4'h7; end
      K_J:    begin r.op = 6'h02; r.jmp = 1; end
      K_JAL:  begin r.op = 6'h03; r.wr = 1; r.jl = 1; r.jmp = 1; end
      K_MULT: begin r.func = 6'h18; r.urs = 1; r.urt = 1; r.mul = 1; end
      default: begin r.func = 6'h12; r.wr = 1; r.mfl = 1; end
    endcase
    return r;
  endfunction

  // Where an operand comes from, given what is in flight in EX and MEM
  function automatic logic [1:0] src_of(input int r);
    if (ex_wr && ex_dst == r && !ex_ld) return 2'd1;
    if (mem_wr && mem_dst == r) return mem_ld ? 2'd3 : 2'd2;
    return 2'd0;
  endfunction

  task automatic issue(input int k, input int a, input int b, input int d,
                       input bit eq, output bit stl);
    info_t f;
    exp_t  e;
    int    dst;
    bit    wr, ldh, mdh;
    f = info(k);
    @(negedge clock);
    reset = 1'b0; op = f.op; func = f.func;
    rs = 5'(a); rt = 5'(b); rd = 5'(d); rsrtequ = eq;

    dst = f.jl ? 31 : (f.drt ? b : d);
    wr  = f.wr && (dst != 0);
    ldh = ex_wr && ex_ld && ((f.urs && ex_dst == a) || (f.urt && ex_dst == b));
    mdh = (f.mul || f.mfl) && (cyc < free_at);
    stl = ldh || mdh;

    e = '0;
    e.wreg = wr && !stl;  e.m2reg = f.ld;  e.wmem = f.st && !stl;
    e.aluc = f.aluc;      e.amask = f.amask;
    e.aluimm = f.imm;     e.shift = f.sh;  e.sext = f.sx;  e.jal = f.jl;
    e.rn = 5'(dst);
    if ((f.beq && eq) || (f.bne && !eq)) e.pcsource = 2'd1;
    else if (f.jr) e.pcsource = 2'd2;
    else if (f.jmp) e.pcsource = 2'd3;
    if (stl) e.pcsource = 2'd0;
    e.fwda = src_of(a);   e.fwdb = src_of(b);
    e.wpcir = !stl;       e.mdu_start = f.mul && !stl;  e.mflo = f.mfl;
    sb.push_back(e);

    mem_wr = ex_wr; mem_ld = ex_ld; mem_dst = ex_dst;
    if (stl) begin
      ex_wr = 0; ex_ld = 0; ex_dst = 0;
    end else begin
      ex_wr = wr; ex_ld = f.ld; ex_dst = dst;
      if (f.mul) free_at = cyc + int'(MDU_LAT) + 1;
    end
    cyc++;
  endtask

  // Reset asserted and released between two rising edges
  task automatic reset_pulse();
    exp_t e;
    @(negedge clock);
    reset = 1'b1; op = '0; func = '0; rs = '0; rt = '0; rd = '0; rsrtequ = 1'b0;
    ex_wr = 0; ex_ld = 0; ex_dst = 0; mem_wr = 0; mem_ld = 0; mem_dst = 0;
    free_at = 0;
    cyc++;
    e = '0; e.wpcir = 1'b1; e.amask = 4'hF;
    sb.push_back(e);
    #3 reset = 1'b0;
  endtask

  // Re-present a stalled instruction until ID accepts it
  task automatic run(input int k, input int a, input int b, input int d, input bit eq);
    bit s;
    int n;
    n = 0;
    do begin
      issue(k, a, b, d, eq, s);
      n++;
    end while (s && n < 40);
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, req);
    end
  endtask

  exp_t me;
  initial begin
    forever begin
      @(negedge clock);
      #2;
      if (sb.size() > 0) begin
        me = sb.pop_front();
        chk("wreg",      8'(wreg),          8'(me.wreg));
        chk("m2reg",     8'(m2reg),         8'(me.m2reg));
        chk("wmem",      8'(wmem),          8'(me.wmem));
        chk("aluc",      8'(aluc & me.amask), 8'(me.aluc & me.amask));
        chk("aluimm",    8'(aluimm),        8'(me.aluimm));
        chk("shift",     8'(shift),         8'(me.shift));
        chk("sext",      8'(sext),          8'(me.sext));
        chk("jal",       8'(jal),           8'(me.jal));
        chk("rn",        8'(rn),            8'(me.rn));
        chk("pcsource",  8'(pcsource),      8'(me.pcsource));
        chk("fwda",      8'(fwda),          8'(me.fwda));
        chk("fwdb",      8'(fwdb),          8'(me.fwdb));
        chk("wpcir",     8'(wpcir),         8'(me.wpcir));
        chk("mdu_start", 8'(mdu_start),     8'(me.mdu_start));
        chk("mflo",      8'(mflo),          8'(me.mflo));
      end
    end
  end

  function automatic int rreg();
    return ($urandom_range(0, 7) == 0) ? 31 : int'($urandom_range(0, 3));
  endfunction

  initial begin
    int k, a, b, d, r;
    bit eq, s, pend;
    reset_pulse();

    // load-use: lw $2,0($1); add $3,$2,$4
    run(K_LW, 1, 2, 0, 0);
    run(K_ADD, 2, 4, 3, 0);
    // EX forward, then MEM forward through a nop
    run(K_ADD, 1, 1, 2, 0);
    run(K_SUB, 2, 2, 5, 0);
    run(K_ADD, 1, 1, 2, 0);
    run(K_SLL, 0, 0, 0, 0);
    run(K_SUB, 2, 2, 5, 0);
    // EX and MEM both write $2: EX wins
    run(K_ADD, 1, 1, 2, 0);
    run(K_ORI, 1, 2, 0, 0);
    run(K_OR, 2, 0, 6, 0);
    // writes to $0 never forward or stall
    run(K_LW, 1, 0, 0, 0);
    run(K_ADD, 0, 0, 7, 0);
    run(K_ADDI, 0, 0, 0, 0);
    run(K_SUB, 0, 0, 7, 0);
    // multiply then dependent mflo
    run(K_MULT, 1, 2, 0, 0);
    run(K_MFLO, 0, 0, 3, 0);
    run(K_ADD, 3, 3, 4, 0);
    // branches and jal
    run(K_BEQ, 1, 2, 0, 1);
    run(K_BNE, 1, 2, 0, 1);
    run(K_BNE, 1, 2, 0, 0);
    run(K_JAL, 0, 0, 0, 0);
    run(K_JR, 31, 0, 0, 0);
    run(K_J, 0, 0, 0, 0);
    // reset mid-multiply abandons it
    run(K_MULT, 1, 2, 0, 0);
    run(K_SLL, 0, 0, 0, 0);
    run(K_SLL, 0, 0, 0, 0);
    reset_pulse();
    run(K_MFLO, 0, 0, 3, 0);
    // back-to-back multiplies and load feeding mult
    run(K_MULT, 1, 2, 0, 0);
    run(K_MULT, 3, 1, 0, 0);
    run(K_LW, 1, 2, 0, 0);
    run(K_MULT, 2, 2, 0, 0);

    pend = 0; k = 0; a = 0; b = 0; d = 0; eq = 0;
    for (int i = 0; i < 700; i++) begin
      if (!pend && $urandom_range(0, 99) == 0) begin
        reset_pulse();
      end else begin
        if (!pend) begin
          r = int'($urandom_range(0, 34));
          if (r < NK) k = r;
          else if (r < 29) k = K_LW;
          else if (r < 32) k = K_MULT;
          else k = K_MFLO;
          a = rreg(); b = rreg(); d = rreg(); eq = 1'($urandom_range(0, 1));
        end
        issue(k, a, b, d, eq, s);
        pend = s;
      end
    end

    repeat (3) @(negedge clock);
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
